seg7_capture: RTL and testbench

//   Receive side of the seven-segment display interface: samples a 7-bit

---
 rtl/seg7_capture.sv | 106 ++++++++++
 tb/tb_seg7_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: settles a synchronised seven-segment bus, decodes it to a hex digit and flags blank/illegal patterns.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       segments,
  input  logic             clear_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             new_digit,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1) + 1;
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t state, state_n;
  logic [6:0] s1, s2, s_prev;
  logic [CW-1:0] cnt, cnt_n;
  logic commit, legal, same;
  logic [3:0] value;
  assign same = s2 == s_prev;
  always_comb begin
    legal = 1'b1;
    value = 4'h0;
    case (s2)
      7'h7E: value = 4'h0;
      7'h30: value = 4'h1;
      7'h6D: value = 4'h2;
      7'h79: value = 4'h3;
      7'h33: value = 4'h4;
      7'h5B: value = 4'h5;
      7'h5F: value = 4'h6;
      7'h70: value = 4'h7;
      7'h7F: value = 4'h8;
      7'h7B: value = 4'h9;
      7'h77: value = 4'hA;
      7'h1F: value = 4'hB;
      7'h4E: value = 4'hC;
      7'h3D: value = 4'hD;
      7'h4F: value = 4'hE;
      7'h47: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // A change always restarts the count at 1 so the commit lands STABLE_CYCLES+2 edges after the input moved
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    commit = 1'b0;
    if (state == SETTLE) begin
      cnt_n = same ? cnt + 1'b1 : CW'(1);
      if (cnt_n >= CW'(STABLE_CYCLES)) begin
        commit = 1'b1;
        state_n = LOCKED;
      end
    end else if (!same) begin
      state_n = SETTLE;
      cnt_n = CW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s_prev <= '0;
      cnt <= '0;
      state <= SETTLE;
    end else begin
      s1 <= ACTIVE_LOW ? ~segments : segments;
      s2 <= s1;
      s_prev <= s2;
      cnt <= cnt_n;
      state <= state_n;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b0;
      new_digit <= 1'b0;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      new_digit <= 1'b0;
      err <= 1'b0;
      if (commit) begin
        digit_valid <= legal;
        blank <= s2 == 7'h00;
        if (legal) begin
          digit <= value;
          new_digit <= !digit_valid || value != digit;
        end
        err <= !legal && s2 != 7'h00;
      end
      if (clear_err)
        err_count <= '0;
      else if (commit && !legal && s2 != 7'h00 && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: table-driven directed checks of settle, decode, pulses, saturation and reset for seg7_capture.
module tb_seg7_capture;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] segments = 7'h00;
  logic clear_err = 1'b0;
  logic [3:0] digit;
  logic digit_valid, blank, new_digit, err;
  logic [1:0] err_count;
  int checks = 0;
  int errors = 0;
  int np = 0;
  int ep = 0;
  typedef struct {
    logic [6:0] seg;
    int cyc;
    int dig;
    int val;
    int blk;
    int nd;
    int er;
    int ec;
  } vec_t;
  vec_t vec [25];

  seg7_capture #(.STABLE_CYCLES(4), .ERR_W(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .segments(segments), .clear_err(clear_err),
    .digit(digit), .digit_valid(digit_valid), .blank(blank),
    .new_digit(new_digit), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (new_digit) np++;
    if (err) ep++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " digit"}, digit, 0);
    chk({tag, " digit_valid"}, digit_valid, 0);
    chk({tag, " blank"}, blank, 0);
    chk({tag, " new_digit"}, new_digit, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " err_count"}, err_count, 0);
  endtask

  initial begin
    vec[0]  = '{7'h6D, 12, 2, 1, 0, 1, 0, 0};
    vec[1]  = '{7'h7F, 2, 2, 1, 0, 0, 0, 0};
    vec[2]  = '{7'h6D, 12, 2, 1, 0, 0, 0, 0};
    vec[3]  = '{7'h79, 12, 3, 1, 0, 1, 0, 0};
    vec[4]  = '{7'h00, 3, 3, 1, 0, 0, 0, 0};
    vec[5]  = '{7'h79, 12, 3, 1, 0, 0, 0, 0};
    vec[6]  = '{7'h33, 12, 4, 1, 0, 1, 0, 0};
    vec[7]  = '{7'h5B, 12, 5, 1, 0, 1, 0, 0};
    vec[8]  = '{7'h5F, 12, 6, 1, 0, 1, 0, 0};
    vec[9]  = '{7'h70, 12, 7, 1, 0, 1, 0, 0};
    vec[10] = '{7'h7F, 12, 8, 1, 0, 1, 0, 0};
    vec[11] = '{7'h7B, 12, 9, 1, 0, 1, 0, 0};
    vec[12] = '{7'h77, 12, 10, 1, 0, 1, 0, 0};
    vec[13] = '{7'h1F, 12, 11, 1, 0, 1, 0, 0};
    vec[14] = '{7'h4E, 12, 12, 1, 0, 1, 0, 0};
    vec[15] = '{7'h3D, 12, 13, 1, 0, 1, 0, 0};
    vec[16] = '{7'h4F, 12, 14, 1, 0, 1, 0, 0};
    vec[17] = '{7'h47, 12, 15, 1, 0, 1, 0, 0};
    vec[18] = '{7'h7E, 12, 0, 1, 0, 1, 0, 0};
    vec[19] = '{7'h01, 20, 0, 0, 0, 0, 1, 1};
    vec[20] = '{7'h00, 12, 0, 0, 1, 0, 0, 1};
    vec[21] = '{7'h02, 12, 0, 0, 0, 0, 1, 2};
    vec[22] = '{7'h03, 12, 0, 0, 0, 0, 1, 3};
    vec[23] = '{7'h04, 12, 0, 0, 0, 0, 1, 3};
    vec[24] = '{7'h05, 12, 0, 0, 0, 0, 1, 3};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    segments = 7'h30;
    np = 0;
    ep = 0;
    for (int k = 1; k <= 5; k++) step();
    chk("t1 valid before latency", digit_valid, 0);
    step();
    chk("t1 valid at latency", digit_valid, 1);
    chk("t1 digit", digit, 1);
    chk("t1 new_digit at commit", new_digit, 1);
    step();
    chk("t1 new_digit cleared", new_digit, 0);
    repeat (5) step();
    chk("t1 new_digit count", np, 1);

    for (int i = 0; i < 25; i++) begin
      segments = vec[i].seg;
      np = 0;
      ep = 0;
      for (int c = 0; c < vec[i].cyc; c++) step();
      chk($sformatf("row%0d digit", i), digit, vec[i].dig);
      chk($sformatf("row%0d digit_valid", i), digit_valid, vec[i].val);
      chk($sformatf("row%0d blank", i), blank, vec[i].blk);
      chk($sformatf("row%0d new_digit pulses", i), np, vec[i].nd);
      chk($sformatf("row%0d err pulses", i), ep, vec[i].er);
      chk($sformatf("row%0d err_count", i), err_count, vec[i].ec);
    end

    segments = 7'h06;
    ep = 0;
    for (int k = 1; k <= 5; k++) step();
    chk("t5 no err before commit", ep, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t5 err pulse with clear", err, 1);
    chk("t5 err_count cleared", err_count, 0);
    chk("t5 new_digit excl", new_digit, 0);

    segments = 7'h00;
    repeat (12) step();
    chk("t6 blank", blank, 1);
    chk("t6 blank valid", digit_valid, 0);
    segments = 7'h47;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk_reset_vals("mid-settle reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    np = 0;
    for (int k = 1; k <= 5; k++) step();
    chk("t6 valid before latency", digit_valid, 0);
    step();
    chk("t6 valid at latency", digit_valid, 1);
    chk("t6 digit F", digit, 15);
    chk("t6 new_digit", np, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
